// File: rtl/sha256_msg_padder_pkg.sv
// Shared definitions for the SHA-256 message padder: FSM states,
// padding constants and a helper that normalises the tail byte count.
package sha256_msg_padder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PAD,
      ST_FILL,
      ST_EMIT,
      ST_WAIT,
      ST_FIN
   } pad_state_e;

   localparam logic [7:0]  PAD_BYTE    = 8'h80;
   localparam int unsigned BLK_WORDS   = 16;
   localparam int unsigned LEN_FIELD_W = 64;
   localparam logic [31:0] PAD_WORD    = {PAD_BYTE, 24'h000000};

   // Byte counts above 4 cannot occur in a 32-bit word; treat them as a full word.
   function automatic logic [2:0] clamp_bytes(input logic [2:0] b);
      return b[2] ? 3'd4 : b;
   endfunction

endpackage

// File: rtl/sha256_msg_padder_pad_word.sv
// Inserts the 0x80 terminator into the tail word right after its valid bytes
// and zeroes everything behind it. A full word (4 bytes) passes through; the
// terminator then goes into the following word.
module sha256_pad_word
   import sha256_msg_padder_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [2:0]  bytes_i,
   output logic [31:0] word_o
);

   // Select the padded layout by number of valid leading bytes.
   always_comb begin
      word_o = data_i;
      case (bytes_i)
         3'd0:    word_o = PAD_WORD;
         3'd1:    word_o = {data_i[31:24], PAD_BYTE, 16'h0000};
         3'd2:    word_o = {data_i[31:16], PAD_BYTE, 8'h00};
         3'd3:    word_o = {data_i[31:8], PAD_BYTE};
         default: word_o = data_i;
      endcase
   end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder feeding the hash core of a feedback-mode KDF.
// Buffers big-endian words into 16-word blocks, applies the 0x80 / zero /
// 64-bit length padding and streams each block as soc + 16 words, then waits
// for core_eoc before touching the buffer again.
// Optional macro PAD_BLKCNT_EN adds the blk_cnt port and its block counter.
module sha256_msg_padder
   import sha256_msg_padder_pkg::*;
#(
   parameter int unsigned LEN_W = 64,
   parameter int unsigned CNT_W = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        in_bytes,
   output logic              out_soc,
   output logic [31:0]       out_word,
   output logic              out_wvalid,
   output logic              out_final,
   input  logic              core_eoc,
   output logic              done
`ifdef PAD_BLKCNT_EN
   ,output logic [CNT_W-1:0] blk_cnt
`endif
);

   // Reject widths the length field or block counter cannot represent.
   if (LEN_W < 8 || LEN_W > LEN_FIELD_W) begin : g_len_w_chk
      $error("sha256_msg_padder: LEN_W must be in 8..64");
   end
   if (CNT_W < 1) begin : g_cnt_w_chk
      $error("sha256_msg_padder: CNT_W must be at least 1");
   end

   pad_state_e              state_q;
   logic [31:0]             blk_q [BLK_WORDS];
   // Fill count 0..16; 16 means the block is full and must be emitted first.
   logic [4:0]              widx_q;
   logic [3:0]              ecnt_q;
   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        len_d;
   logic                    pend80_q;
   logic                    tail_q;
   logic                    last_blk_q;
   logic                    in_ready_q;
   logic                    out_soc_q;
   logic [31:0]             out_word_q;
   logic                    out_wvalid_q;
   logic                    out_final_q;
   logic                    done_q;

   logic [2:0]              bytes_eff;
   logic [31:0]             pad_word;
   logic [31:0]             wr_word_d;
   logic                    accept;
   logic [LEN_FIELD_W-1:0]  len_field;

   sha256_pad_word u_pad_word (
      .data_i  (in_data),
      .bytes_i (bytes_eff),
      .word_o  (pad_word)
   );

   // Transfer qualification, word to store and the updated bit length.
   always_comb begin
      bytes_eff = clamp_bytes(in_bytes);
      accept    = in_valid & in_ready_q;
      wr_word_d = (in_last && bytes_eff != 3'd4) ? pad_word : in_data;
      len_d     = len_q + (in_last ? (LEN_W'(bytes_eff) << 3) : LEN_W'(32));
      len_field = LEN_FIELD_W'(len_q);
   end

   // Main FSM: load, pad, fill, emit, wait for the core, finish.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         widx_q       <= '0;
         ecnt_q       <= '0;
         len_q        <= '0;
         pend80_q     <= 1'b0;
         tail_q       <= 1'b0;
         last_blk_q   <= 1'b0;
         in_ready_q   <= 1'b0;
         out_soc_q    <= 1'b0;
         out_word_q   <= '0;
         out_wvalid_q <= 1'b0;
         out_final_q  <= 1'b0;
         done_q       <= 1'b0;
         for (int unsigned i = 0; i < BLK_WORDS; i++) begin
            blk_q[4'(i)] <= '0;
         end
      end else begin
         out_soc_q <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               state_q    <= ST_LOAD;
               in_ready_q <= 1'b1;
            end

            ST_LOAD: begin
               if (accept) begin
                  blk_q[widx_q[3:0]] <= wr_word_d;
                  len_q              <= len_d;
                  widx_q             <= widx_q + 5'd1;
                  if (in_last) begin
                     tail_q     <= 1'b1;
                     pend80_q   <= (bytes_eff == 3'd4);
                     in_ready_q <= 1'b0;
                     state_q    <= ST_PAD;
                  end else if (widx_q == 5'd15) begin
                     in_ready_q  <= 1'b0;
                     state_q     <= ST_EMIT;
                     ecnt_q      <= '0;
                     out_soc_q   <= 1'b1;
                     out_final_q <= 1'b0;
                     last_blk_q  <= 1'b0;
                  end
               end
            end

            // A full last word whose block is already full flushes that block
            // first; the terminator word then starts the next block.
            ST_PAD: begin
               if (pend80_q && widx_q == 5'd16) begin
                  state_q     <= ST_EMIT;
                  ecnt_q      <= '0;
                  out_soc_q   <= 1'b1;
                  out_final_q <= 1'b0;
                  last_blk_q  <= 1'b0;
               end else begin
                  if (pend80_q) begin
                     blk_q[widx_q[3:0]] <= PAD_WORD;
                     widx_q             <= widx_q + 5'd1;
                     pend80_q           <= 1'b0;
                  end
                  state_q <= ST_FILL;
               end
            end

            // Length fits behind the terminator only if words 14/15 are free;
            // otherwise this block is zero-filled and a length-only block follows.
            ST_FILL: begin
               state_q   <= ST_EMIT;
               ecnt_q    <= '0;
               out_soc_q <= 1'b1;
               if (widx_q <= 5'd14) begin
                  for (int unsigned i = 0; i < 14; i++) begin
                     if (5'(i) >= widx_q) begin
                        blk_q[4'(i)] <= '0;
                     end
                  end
                  blk_q[14]   <= len_field[63:32];
                  blk_q[15]   <= len_field[31:0];
                  out_final_q <= 1'b1;
                  last_blk_q  <= 1'b1;
               end else begin
                  for (int unsigned i = 0; i < BLK_WORDS; i++) begin
                     if (5'(i) >= widx_q) begin
                        blk_q[4'(i)] <= '0;
                     end
                  end
                  out_final_q <= 1'b0;
                  last_blk_q  <= 1'b0;
               end
            end

            ST_EMIT: begin
               out_wvalid_q <= 1'b1;
               out_word_q   <= blk_q[ecnt_q];
               ecnt_q       <= ecnt_q + 4'd1;
               if (ecnt_q == 4'd15) begin
                  state_q <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               out_wvalid_q <= 1'b0;
               out_word_q   <= '0;
               out_final_q  <= 1'b0;
               if (core_eoc) begin
                  if (last_blk_q) begin
                     state_q <= ST_FIN;
                     done_q  <= 1'b1;
                  end else begin
                     widx_q <= '0;
                     if (tail_q) begin
                        state_q <= ST_PAD;
                     end else begin
                        state_q    <= ST_LOAD;
                        in_ready_q <= 1'b1;
                     end
                  end
               end
            end

            ST_FIN: begin
               len_q      <= '0;
               widx_q     <= '0;
               tail_q     <= 1'b0;
               pend80_q   <= 1'b0;
               last_blk_q <= 1'b0;
               state_q    <= ST_LOAD;
               in_ready_q <= 1'b1;
            end

            default: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef PAD_BLKCNT_EN
   logic [CNT_W-1:0] blk_cnt_q;
   logic             first_q;

   // Saturating count of emitted blocks, restarted by a new message's first word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blk_cnt_q <= '0;
         first_q   <= 1'b1;
      end else begin
         if (accept && first_q) begin
            blk_cnt_q <= '0;
         end else if (out_soc_q && blk_cnt_q != '1) begin
            blk_cnt_q <= blk_cnt_q + CNT_W'(1);
         end
         if (state_q == ST_FIN) begin
            first_q <= 1'b1;
         end else if (accept) begin
            first_q <= 1'b0;
         end
      end
   end

   assign blk_cnt = blk_cnt_q;
`endif

   assign in_ready   = in_ready_q;
   assign out_soc    = out_soc_q;
   assign out_word   = out_word_q;
   assign out_wvalid = out_wvalid_q;
   assign out_final  = out_final_q;
   assign done       = done_q;

endmodule
